// File: rtl/rename_map_unit.sv
// Register-rename stage: speculative/committed alias tables and free vectors, issue handshake,
// ROB retire and single-cycle flush recovery. Optional arch-reg-0 hardwiring via RENAME_X0_HARDWIRE_EN.
module rename_map_unit #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int ARCH_W   = $clog2(NUM_ARCH),
    parameter int PHYS_W   = $clog2(NUM_PHYS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ARCH_W-1:0] issue_rs1,
    input  logic [ARCH_W-1:0] issue_rs2,
    input  logic [ARCH_W-1:0] issue_rd,
    input  logic              issue_has_rd,
    output logic [PHYS_W-1:0] phys_rs1,
    output logic [PHYS_W-1:0] phys_rs2,
    output logic [PHYS_W-1:0] phys_rd,
    output logic [PHYS_W-1:0] old_phys_rd,
    input  logic              retire_valid,
    input  logic [ARCH_W-1:0] retire_rd,
    input  logic [PHYS_W-1:0] retire_phys_rd,
    input  logic [PHYS_W-1:0] retire_old_phys_rd,
    input  logic              flush,
    output logic [PHYS_W:0]   free_count
);

`ifdef RENAME_X0_HARDWIRE_EN
    localparam bit X0_HW = 1'b1;
`else
    localparam bit X0_HW = 1'b0;
`endif

    localparam logic [PHYS_W:0]     INIT_COUNT = (PHYS_W+1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [NUM_PHYS-1:0] INIT_FREE  = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

    logic [PHYS_W-1:0]   srat [NUM_ARCH];
    logic [PHYS_W-1:0]   crat [NUM_ARCH];
    logic [NUM_PHYS-1:0] spec_free, com_free;
    logic [NUM_PHYS-1:0] spec_free_nxt, com_free_nxt;
    logic [PHYS_W:0]     com_pop;
    logic                issue_fire, rd_zero, alloc, retire_en;

    assign issue_ready = (free_count != '0);
    assign issue_fire  = issue_valid & issue_ready & ~flush;
    assign rd_zero     = X0_HW && (issue_rd == '0);
    assign alloc       = issue_fire & issue_has_rd & ~rd_zero;
    assign retire_en   = retire_valid & ~(X0_HW && (retire_rd == '0));

    // Sources read the pre-rename table, so rs == rd naturally sees the old mapping.
    assign phys_rs1    = srat[issue_rs1];
    assign phys_rs2    = srat[issue_rs2];
    assign old_phys_rd = rd_zero ? '0 : srat[issue_rd];

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    always_comb begin
        phys_rd = '1;
        for (int i = NUM_PHYS - 1; i >= 0; i--) begin
            if (spec_free[i]) phys_rd = PHYS_W'(i);
        end
    end

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        com_free_nxt  = com_free;
        spec_free_nxt = spec_free;
        if (alloc) spec_free_nxt[phys_rd] = 1'b0;
        if (retire_en) begin
            com_free_nxt[retire_phys_rd]      = 1'b0;
            com_free_nxt[retire_old_phys_rd]  = 1'b1;
            spec_free_nxt[retire_old_phys_rd] = 1'b1;
        end
        if (X0_HW) begin
            com_free_nxt[0]  = 1'b0;
            spec_free_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        com_pop = '0;
        for (int i = 0; i < NUM_PHYS; i++) com_pop += (PHYS_W+1)'(com_free_nxt[i]);
    end

    // NOTE: the alias tables are small flop arrays, not RAM, so they take an identity reset.
    // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                srat[i] <= PHYS_W'(i);
                crat[i] <= PHYS_W'(i);
            end
            spec_free  <= INIT_FREE;
            com_free   <= INIT_FREE;
            free_count <= INIT_COUNT;
        end else begin
            if (retire_en) crat[retire_rd] <= retire_phys_rd;
            com_free <= com_free_nxt;
            if (flush) begin
                for (int i = 0; i < NUM_ARCH; i++) begin
                    srat[i] <= (retire_en && retire_rd == ARCH_W'(i)) ? retire_phys_rd : crat[i];
                end
                spec_free  <= com_free_nxt;
                free_count <= com_pop;
            end else begin
                if (alloc) srat[issue_rd] <= phys_rd;
                spec_free  <= spec_free_nxt;
                free_count <= free_count + (PHYS_W+1)'(retire_en) - (PHYS_W+1)'(alloc);
            end
        end
    end

`ifndef SYNTHESIS
    a_retire_distinct: assert property (@(posedge clk) disable iff (!reset_n)
        retire_en |-> (retire_old_phys_rd != retire_phys_rd));
    a_retire_not_free: assert property (@(posedge clk) disable iff (!reset_n)
        retire_en |-> !com_free[retire_old_phys_rd]);
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        free_count <= INIT_COUNT);
`endif

endmodule

// File: tb/tb_rename_map_unit.sv
// Scoreboarded bench for rename_map_unit: directed scenarios then random traffic against
// a table/free-set reference model with an in-order ROB queue driving legal retires.
module tb_rename_map_unit;

    localparam int NA = 32;
    localparam int NP = 64;
    localparam int AW = $clog2(NA);
    localparam int PW = $clog2(NP);

`ifdef RENAME_X0_HARDWIRE_EN
    localparam bit X0_HW = 1'b1;
`else
    localparam bit X0_HW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          issue_valid = 1'b0, issue_ready, issue_has_rd = 1'b0;
    logic [AW-1:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic [PW-1:0] phys_rs1, phys_rs2, phys_rd, old_phys_rd;
    logic          retire_valid = 1'b0, flush = 1'b0;
    logic [AW-1:0] retire_rd = '0;
    logic [PW-1:0] retire_phys_rd = '0, retire_old_phys_rd = '0;
    logic [PW:0]   free_count;

    rename_map_unit #(.NUM_ARCH(NA), .NUM_PHYS(NP)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_has_rd(issue_has_rd),
        .phys_rs1(phys_rs1), .phys_rs2(phys_rs2), .phys_rd(phys_rd), .old_phys_rd(old_phys_rd),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .retire_phys_rd(retire_phys_rd), .retire_old_phys_rd(retire_old_phys_rd),
        .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct { int rs1p; int rs2p; int rdp; int oldp; bit has_alloc; } exp_t;
    typedef struct { int rd; int newp; int oldp; } rob_t;

    exp_t exp_q[$];
    rob_t rob[$];
    int   m_srat[NA];
    int   m_crat[NA];
    bit   m_sfree[NP];
    bit   m_cfree[NP];
    int   cur_fc;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NP; i++) c += int'(m_sfree[i]);
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < NP; i++) if (m_sfree[i]) return i;
        return NP - 1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NA; i++) begin
            m_srat[i] = i;
            m_crat[i] = i;
        end
        for (int i = 0; i < NP; i++) begin
            m_sfree[i] = (i >= NA);
            m_cfree[i] = (i >= NA);
        end
        rob.delete();
    endfunction

    // One cycle of stimulus; the model is advanced to the state after the coming edge.
    task automatic step(bit v, int rs1, int rs2, int rd, bit hr, bit ret, bit fl);
        bit fire, x0, alloc;
        int p, old;
        rob_t r;
        @(posedge clk);
        #1;
        cur_fc = m_count();
        fire   = v && (cur_fc != 0) && !fl;
        x0     = X0_HW && (rd == 0);
        alloc  = fire && hr && !x0;
        p      = m_lowest();
        old    = x0 ? 0 : m_srat[rd];
        issue_valid  = v;
        issue_rs1    = AW'(rs1);
        issue_rs2    = AW'(rs2);
        issue_rd     = AW'(rd);
        issue_has_rd = hr;
        flush        = fl;
        if (fire) exp_q.push_back('{m_srat[rs1], m_srat[rs2], p, old, alloc});
        retire_valid = 1'b0;
        if (ret && rob.size() > 0) begin
            r = rob.pop_front();
            retire_valid       = 1'b1;
            retire_rd          = AW'(r.rd);
            retire_phys_rd     = PW'(r.newp);
            retire_old_phys_rd = PW'(r.oldp);
            m_crat[r.rd]   = r.newp;
            m_cfree[r.newp] = 1'b0;
            m_cfree[r.oldp] = 1'b1;
            m_sfree[r.oldp] = 1'b1;
        end
        if (alloc) begin
            m_srat[rd] = p;
            m_sfree[p] = 1'b0;
            rob.push_back('{rd, p, old});
        end
        if (fl) begin
            m_srat  = m_crat;
            m_sfree = m_cfree;
            rob.delete();
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted with a live issue request; nothing may rename across it.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        issue_valid  = 1'b1;
        issue_has_rd = 1'b1;
        issue_rd     = AW'(3);
        retire_valid = 1'b0;
        flush        = 1'b0;
        m_reset();
        exp_q.delete();
        cur_fc = NP - NA;
        repeat (2) @(posedge clk);
        #1;
        reset_n     = 1'b1;
        issue_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("free_count", int'(free_count), cur_fc);
            check("issue_ready", int'(issue_ready), int'(cur_fc != 0));
            if (issue_valid && issue_ready && !flush) begin
                check("sb_nonempty", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("phys_rs1", int'(phys_rs1), e.rs1p);
                    check("phys_rs2", int'(phys_rs2), e.rs2p);
                    check("old_phys_rd", int'(old_phys_rd), e.oldp);
                    if (e.has_alloc) check("phys_rd", int'(phys_rd), e.rdp);
                end
            end
        end
    end

    initial begin
        m_reset();
        cur_fc = NP - NA;
        do_reset();

        // Basic lookup, then observe SRAT[3] through a later source read.
        step(1, 1, 2, 3, 1, 0, 0);
        step(1, 3, 0, 9, 0, 0, 0);
        // Fill the free list, then hold a request while empty.
        for (int i = 0; i < 31; i++) step(1, i % NA, (i + 1) % NA, (i + 4) % NA, 1, 0, 0);
        step(1, 1, 1, 6, 1, 0, 0);
        step(1, 1, 1, 6, 1, 1, 0);   // retire {3,32,3} while empty
        step(1, 0, 0, 10, 1, 0, 0);  // gets phys 3
        idle(2);

        // Flush restores committed mappings.
        do_reset();
        step(1, 0, 0, 5, 1, 0, 0);
        step(1, 5, 0, 5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 0, 6, 1, 0, 0);

        // Intra-instruction hazard and simultaneous issue + retire.
        do_reset();
        step(1, 7, 7, 7, 1, 0, 0);
        step(1, 4, 0, 4, 1, 0, 0);
        step(1, 7, 4, 8, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0);   // rd 0 (hardwired when the option is built)
        step(1, 8, 0, 9, 1, 1, 1);   // flush with same-cycle retire
        step(1, 7, 8, 2, 1, 0, 0);
        idle(1);

        // Randomised traffic with occasional flush and mid-run reset.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, NA - 1)), int'($urandom_range(0, NA - 1)),
                 int'($urandom_range(0, NA - 1)), $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
        end
        idle(3);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
